nf_result_filter_avlstrm: RTL

//  Stage directly downstream of the non-fast-pattern matcher (after its bypass-back merge); consumes its out_pkt/out_meta/out_usr.
//  Per packet: joins 1 meta + 1 multi-beat rule msg + 1 multi-beat pkt; counts matched (non-zero) rule IDs; decides forward/drop.

---
 rtl/nf_result_filter_avlstrm_if.sv | 32 +++
 rtl/nf_result_filter_avlstrm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_result_filter_avlstrm_if.sv
// Avalon-ST style beat bundle with sop/eop/empty, plus the metadata record
// that travels alongside each packet.
package nf_result_filter_pkg;
    typedef struct packed {
        logic [31:0] pkt_id;
        logic [15:0] flow_id;
        logic [15:0] pkt_len;
    } metadata_t;
endpackage

interface nf_result_filter_avlstrm_if #(
    parameter int W = 512
);
    localparam int EW = (W > 8) ? $clog2(W / 8) : 1;

    logic          valid;
    logic          ready;
    logic          sop;
    logic          eop;
    logic [W-1:0]  data;
    logic [EW-1:0] empty;

    modport master (
        output valid, sop, eop, data, empty,
        input  ready
    );

    modport slave (
        input  valid, sop, eop, data, empty,
        output ready
    );
endinterface

// File: rtl/nf_result_filter_avlstrm.sv
// Joins meta + rule message + packet, counts matched rule IDs, forwards or drops.
// Build option: NF_RESULT_ZERO_DROP_EN drops packets with no matched rule and no overflow.
module nf_result_filter_avlstrm #(
    parameter int RULE_W         = 16,
    parameter int MAX_RULE_BEATS = 4,
    parameter int DATA_W         = 512,
    parameter int META_W         = 64
) (
    input  logic clk,
    input  logic rst_n,
    nf_result_filter_avlstrm_if.slave  in_pkt,
    nf_result_filter_avlstrm_if.slave  in_meta,
    nf_result_filter_avlstrm_if.slave  in_usr,
    nf_result_filter_avlstrm_if.master out_pkt,
    nf_result_filter_avlstrm_if.master out_meta,
    nf_result_filter_avlstrm_if.master out_usr,
    output logic [31:0] stats_fwd_pkt,
    output logic [31:0] stats_drop_pkt,
    output logic [31:0] stats_rule_ovf
);
    localparam int NUM_IDS = DATA_W / RULE_W;
    localparam int CW      = $clog2(NUM_IDS + 1);
    localparam int PW      = $clog2(MAX_RULE_BEATS + 1);
    localparam int IW      = $clog2(MAX_RULE_BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RULE_RX,
        S_DECIDE,
        S_META_TX,
        S_RULE_TX,
        S_PKT_FWD,
        S_PKT_DROP
    } state_t;

    state_t state;

    logic              meta_rdy;
    logic              usr_rdy;
    logic              meta_vld;
    logic              usr_vld;
    logic              fwd_en;
    logic              drop_en;
    logic              ovf;
    logic [META_W-1:0] meta_q;
    logic [15:0]       rule_cnt;
    logic [PW-1:0]     wr_ptr;
    logic [IW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rule_buf [MAX_RULE_BEATS];

    logic [CW-1:0]     nz_cnt;
    logic [16:0]       cnt_sum;
    logic              keep;
    logic              usr_last;
    logic              usr_in_xfer;
    logic              buf_wr;
    logic              pkt_eop_xfer;

    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            nz_cnt = nz_cnt + CW'(|in_usr.data[i*RULE_W +: RULE_W]);
        end
    end

    assign cnt_sum = {1'b0, rule_cnt} + 17'(nz_cnt);

`ifdef NF_RESULT_ZERO_DROP_EN
    assign keep = (rule_cnt != 16'd0) || ovf;
`else
    assign keep = 1'b1;
`endif

    assign usr_last     = (PW'(rd_ptr) + PW'(1)) == wr_ptr;
    assign usr_in_xfer  = in_usr.valid && usr_rdy;
    assign buf_wr       = usr_in_xfer && (wr_ptr < PW'(MAX_RULE_BEATS));
    assign pkt_eop_xfer = in_pkt.valid && in_pkt.ready && in_pkt.eop;

    assign in_meta.ready = meta_rdy;
    assign in_usr.ready  = usr_rdy;
    assign in_pkt.ready  = drop_en || (fwd_en && out_pkt.ready);

    // Packet path is a zero-latency passthrough while forwarding
    assign out_pkt.valid = fwd_en && in_pkt.valid;
    assign out_pkt.data  = in_pkt.data;
    assign out_pkt.sop   = in_pkt.sop;
    assign out_pkt.eop   = in_pkt.eop;
    assign out_pkt.empty = in_pkt.empty;

    assign out_meta.valid = meta_vld;
    assign out_meta.data  = meta_q;
    assign out_meta.sop   = 1'b1;
    assign out_meta.eop   = 1'b1;
    assign out_meta.empty = '0;

    assign out_usr.valid = usr_vld;
    assign out_usr.data  = rule_buf[rd_ptr];
    assign out_usr.sop   = (rd_ptr == '0);
    assign out_usr.eop   = usr_last;
    assign out_usr.empty = '0;

    always_ff @(posedge clk) begin
        if (buf_wr) begin
            rule_buf[wr_ptr[IW-1:0]] <= in_usr.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            meta_rdy       <= 1'b0;
            usr_rdy        <= 1'b0;
            meta_vld       <= 1'b0;
            usr_vld        <= 1'b0;
            fwd_en         <= 1'b0;
            drop_en        <= 1'b0;
            ovf            <= 1'b0;
            meta_q         <= '0;
            rule_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            stats_fwd_pkt  <= '0;
            stats_drop_pkt <= '0;
            stats_rule_ovf <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    meta_rdy <= 1'b1;
                    if (meta_rdy && in_meta.valid) begin
                        meta_q   <= in_meta.data;
                        meta_rdy <= 1'b0;
                        usr_rdy  <= 1'b1;
                        state    <= S_RULE_RX;
                    end
                end
                S_RULE_RX: begin
                    if (usr_in_xfer) begin
                        rule_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                        if (buf_wr) begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (in_usr.eop) begin
                            usr_rdy <= 1'b0;
                            state   <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    if (ovf) begin
                        stats_rule_ovf <= stats_rule_ovf + 32'd1;
                    end
                    // Empty rule set collapses to one all-zero beat
                    if (rule_cnt == 16'd0 && !ovf) begin
                        wr_ptr <= PW'(1);
                    end
                    if (keep) begin
                        meta_vld <= 1'b1;
                        state    <= S_META_TX;
                    end else begin
                        drop_en <= 1'b1;
                        state   <= S_PKT_DROP;
                    end
                end
                S_META_TX: begin
                    if (out_meta.ready) begin
                        meta_vld <= 1'b0;
                        usr_vld  <= 1'b1;
                        rd_ptr   <= '0;
                        state    <= S_RULE_TX;
                    end
                end
                S_RULE_TX: begin
                    if (out_usr.ready) begin
                        if (usr_last) begin
                            usr_vld <= 1'b0;
                            fwd_en  <= 1'b1;
                            state   <= S_PKT_FWD;
                        end else begin
                            rd_ptr <= rd_ptr + IW'(1);
                        end
                    end
                end
                S_PKT_FWD: begin
                    if (pkt_eop_xfer) begin
                        stats_fwd_pkt <= stats_fwd_pkt + 32'd1;
                        fwd_en        <= 1'b0;
                        meta_rdy      <= 1'b1;
                        rule_cnt      <= '0;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        ovf           <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                S_PKT_DROP: begin
                    if (pkt_eop_xfer) begin
                        stats_drop_pkt <= stats_drop_pkt + 32'd1;
                        drop_en        <= 1'b0;
                        meta_rdy       <= 1'b1;
                        rule_cnt       <= '0;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                        ovf            <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
